// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Multi-cycle load/store initiator between the CPU datapath and
//             the unified instruction/data memory. Accepts one request at a
//             time, checks funct3 legality, alignment and address range,
//             performs byte/halfword stores as read-modify-write of the
//             containing word, returns sign/zero-extended loads, and reports
//             faults both to the CPU and into the memory-mapped Cause register.
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             i_req/i_we/i_funct3  - request strobe, store flag, width code
//             i_addr/i_wdata       - byte address and store data
//             o_busy/o_done/o_fault- status, completion pulse, abort flag
//             o_rdata              - extended load result (held)
//             o_mem_addr/o_mem_wdata/o_MemRead/o_MemWrite/i_mem_rdata
//                                  - word-wide memory port
//             o_causeWrite/o_cause_code - Cause register write port
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter logic [31:0] CAUSE_ADDR = 32'h0000_0800,
    parameter int unsigned MEM_BYTES  = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_MemRead,
    output logic        o_MemWrite,
    input  logic [31:0] i_mem_rdata,
    output logic        o_causeWrite,
    output logic [31:0] o_cause_code
);

    localparam logic [31:0] c_MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_FAULT  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic [3:0]  r_code;
    logic        r_fault;

    // ------------------------------------------------------------------
    // Request decode, evaluated on the live inputs while IDLE
    // ------------------------------------------------------------------
    logic        w_illegal;
    logic        w_misalign;
    logic        w_out_of_range;
    logic        w_any_fault;
    logic [3:0]  w_code;

    always_comb begin
        // Unsigned variants only exist for loads; 011/11x never exist.
        w_illegal      = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                         (i_funct3 == 3'b111) || (i_we && i_funct3[2]);
        w_misalign     = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                         ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        // The Cause register word is the only legal hole above memory.
        w_out_of_range = (i_addr >= c_MEM_LIMIT) &&
                         (i_addr[31:2] != CAUSE_ADDR[31:2]);
        w_any_fault    = w_illegal || w_misalign || w_out_of_range;

        if (w_illegal) begin
            w_code = 4'd2;
        end else if (w_misalign) begin
            w_code = i_we ? 4'd6 : 4'd4;
        end else if (w_out_of_range) begin
            w_code = i_we ? 4'd7 : 4'd5;
        end else begin
            w_code = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction / extension and store lane merge
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merge;

    always_comb begin
        w_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = i_mem_rdata[{r_addr[1], 4'b0000} +: 16];
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_load_ext = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_load_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = i_mem_rdata;
        // Only SB (000) and SH (001) reach RMW, so funct3[0] picks the width.
        if (r_funct3[0]) begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end else begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and Moore memory-control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_MemRead    = 1'b0;
        o_MemWrite   = 1'b0;
        o_causeWrite = 1'b0;
        o_mem_wdata  = 32'h0;
        o_cause_code = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_any_fault) begin
                        w_state_next = S_FAULT;
                    end else if (!i_we) begin
                        w_state_next = S_LOAD;
                    end else if (i_funct3[1:0] == 2'b10) begin
                        w_state_next = S_STORE;
                    end else begin
                        w_state_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                o_MemRead    = 1'b1;
                w_state_next = S_DONE;
            end
            S_STORE: begin
                o_MemWrite   = 1'b1;
                o_mem_wdata  = r_wdata;
                w_state_next = S_DONE;
            end
            S_RMW_RD: begin
                o_MemRead    = 1'b1;
                w_state_next = S_RMW_WR;
            end
            S_RMW_WR: begin
                o_MemWrite   = 1'b1;
                o_mem_wdata  = r_merge;
                w_state_next = S_DONE;
            end
            S_FAULT: begin
                o_causeWrite = 1'b1;
                o_cause_code = {28'h0, r_code};
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_code   <= 4'h0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_req) begin
                r_funct3 <= i_funct3;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
                r_code   <= w_code;
                r_fault  <= w_any_fault;
            end
            if (r_state == S_LOAD) begin
                r_rdata <= w_load_ext;
            end
            if (r_state == S_RMW_RD) begin
                r_merge <= w_merge;
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_fault    = (r_state == S_DONE) && r_fault;
    assign o_rdata    = r_rdata;
    assign o_mem_addr = {r_addr[31:2], 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit. A driver issues
//             directed and random requests and pushes the reference model's
//             expectation into a queue; a monitor pops and compares on done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_busy, o_done, o_fault;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, o_cause_code;
    logic        o_MemRead, o_MemWrite, o_causeWrite;
    logic [31:0] i_mem_rdata;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_fault      (o_fault),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_MemRead    (o_MemRead),
        .o_MemWrite   (o_MemWrite),
        .i_mem_rdata  (i_mem_rdata),
        .o_causeWrite (o_causeWrite),
        .o_cause_code (o_cause_code)
    );

    always #5 clk = ~clk;

    // ---------------- memory attached to the DUT ----------------
    logic [31:0] tb_mem [0:511];
    logic [31:0] tb_cause = 32'h0;

    assign i_mem_rdata = !o_MemRead ? 32'h0 :
                         (o_mem_addr[31:2] == 30'h200) ? tb_cause : tb_mem[o_mem_addr[10:2]];

    always @(posedge clk) begin
        if (o_MemWrite) begin
            if (o_mem_addr[31:2] == 30'h200) tb_cause = o_mem_wdata;
            else                             tb_mem[o_mem_addr[10:2]] = o_mem_wdata;
        end
        if (o_causeWrite) tb_cause = o_cause_code;
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:511];
    logic [31:0] ref_cause = 32'h0;
    logic [31:0] ref_rdata = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
        int          ncw;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: RISC-V load/store semantics on a word array.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output exp_t e);
        logic [31:0] size, mask, word, val, code;
        int          sh;
        size = 32'd1 << f3[1:0];
        code = 0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]))
            code = 2;
        else if ((a % size) != 0)
            code = we ? 6 : 4;
        else if (a >= 2048 && (a / 4) != (32'h800 / 4))
            code = we ? 7 : 5;
        e.nrd = 0; e.nwr = 0; e.ncw = 0;
        if (code != 0) begin
            ref_cause = code;
            e.fault = 1'b1; e.lat = 2; e.ncw = 1; e.rdata = ref_rdata;
        end else begin
            word = (a / 4 == 32'h200) ? ref_cause : ref_mem[a[10:2]];
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
            sh   = 8 * int'(a % 4);
            e.fault = 1'b0;
            if (!we) begin
                val = (word >> sh) & mask;
                if (!f3[2] && size < 4 && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
                ref_rdata = val;
                e.lat = 2; e.nrd = 1;
            end else begin
                word = (word & ~(mask << sh)) | ((wd & mask) << sh);
                if (a / 4 == 32'h200) ref_cause = word;
                else                  ref_mem[a[10:2]] = word;
                e.nwr = 1;
                e.nrd = (size < 4) ? 1 : 0;
                e.lat = (size < 4) ? 3 : 2;
            end
            e.rdata = ref_rdata;
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int   m_cyc = 0, m_rd = 0, m_wr = 0, m_cw = 0;
    logic m_excl_bad = 1'b0;
    exp_t m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cyc = 0; m_rd = 0; m_wr = 0; m_cw = 0; m_excl_bad = 1'b0;
        end else begin
            if (o_busy)       m_cyc++;
            if (o_MemRead)    m_rd++;
            if (o_MemWrite)   m_wr++;
            if (o_causeWrite) m_cw++;
            if (int'(o_MemRead) + int'(o_MemWrite) + int'(o_causeWrite) > 1) m_excl_bad = 1'b1;
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rdata",      o_rdata,        m_e.rdata);
                    chk("fault",      32'(o_fault),   32'(m_e.fault));
                    chk("latency",    32'(m_cyc),     32'(m_e.lat));
                    chk("memread_n",  32'(m_rd),      32'(m_e.nrd));
                    chk("memwrite_n", 32'(m_wr),      32'(m_e.nwr));
                    chk("causewr_n",  32'(m_cw),      32'(m_e.ncw));
                    chk("exclusive",  32'(m_excl_bad), 32'd0);
                end
                m_cyc = 0; m_rd = 0; m_wr = 0; m_cw = 0; m_excl_bad = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic setw(input int idx, input logic [31:0] v);
        tb_mem[idx]  = v;
        ref_mem[idx] = v;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   got;
        model(we, f3, a, wd, e);
        exp_q.push_back(e);
        @(negedge clk);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        @(posedge clk);
        #1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_done) begin
                got = 1;
                break;
            end
            // Requests while busy must be ignored.
            i_req    = 1'($urandom_range(0, 1));
            i_we     = 1'($urandom_range(0, 1));
            i_funct3 = 3'($urandom_range(0, 7));
            i_addr   = $urandom;
            i_wdata  = $urandom;
        end
        // A request during DONE must be ignored too.
        i_req = 1'($urandom_range(0, 1));
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("mem_word", tb_mem[a[10:2]], ref_mem[a[10:2]]);
        chk("cause_reg", tb_cause, ref_cause);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(o_busy),       32'd0);
        chk({tag, "_done"},  32'(o_done),       32'd0);
        chk({tag, "_fault"}, 32'(o_fault),      32'd0);
        chk({tag, "_rd"},    32'(o_MemRead),    32'd0);
        chk({tag, "_wr"},    32'(o_MemWrite),   32'd0);
        chk({tag, "_cw"},    32'(o_causeWrite), 32'd0);
        chk({tag, "_rdata"}, o_rdata,           32'd0);
        chk({tag, "_maddr"}, o_mem_addr,        32'd0);
        chk({tag, "_mwd"},   o_mem_wdata,       32'd0);
        chk({tag, "_code"},  o_cause_code,      32'd0);
    endtask

    int          nbad;
    logic [31:0] orig;
    logic [31:0] ra;
    int          sel;

    initial begin
        for (int i = 0; i < 512; i++) setw(i, $urandom);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LW
        setw(4, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_const", o_rdata, 32'hDEADBEEF);

        // LB / LBU sign and zero extension
        setw(4, 32'h80FF1234);
        do_req(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_const", o_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_const", o_rdata, 32'h00000080);

        // SB read-modify-write
        setw(8, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h21, 32'h000000AA);
        chk("sb_const", tb_mem[8], 32'h1122AA44);

        // Legal and faulting accesses
        do_req(1'b0, 3'b001, 32'h02, 32'h0);
        do_req(1'b0, 3'b001, 32'h03, 32'h0);
        chk("lh_mis_cause", tb_cause, 32'd4);
        do_req(1'b1, 3'b010, 32'h06, 32'h12345678);
        chk("sw_mis_cause", tb_cause, 32'd6);
        do_req(1'b0, 3'b010, 32'h900, 32'h0);
        chk("range_cause", tb_cause, 32'd5);

        // Cause register access
        do_req(1'b1, 3'b010, 32'h800, 32'h0000000B);
        do_req(1'b0, 3'b010, 32'h800, 32'h0);
        chk("cause_lw_const", o_rdata, 32'h0000000B);
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        chk("illegal_cause", tb_cause, 32'd2);

        // Reset while RMW_WR is writing
        orig = tb_mem[12];
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h31; i_wdata = 32'h55;
        @(posedge clk);
        #1 i_req = 1'b0;
        @(posedge clk);
        #2;
        chk("rmw_wr_active", 32'(o_MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_rdata = 32'h0;
        chk("rst_mem_kept", tb_mem[12], orig);

        // Requests honoured after reset
        do_req(1'b1, 3'b001, 32'h32, 32'h0000BEEF);
        do_req(1'b0, 3'b101, 32'h32, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      ra = 32'($urandom_range(0, 63));
            else if (sel <= 7) ra = 32'h800 + 32'($urandom_range(0, 7));
            else if (sel == 8) ra = 32'($urandom_range(2040, 2047));
            else               ra = $urandom;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
        end

        @(negedge clk);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        nbad = 0;
        for (int i = 0; i < 512; i++) if (tb_mem[i] !== ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
